// File: rtl/bm_dag3_accum_if.sv
// ---------------------------------------------------------------------------
// bm_dag3_accum_if
//
// Bundles the two streams of the windowed accumulator:
//   input stream  : in_valid / in_data / in_ready
//   output stream : out_valid / out_ready / out_sum / out_max / out_min / out_ovf
//   debug         : dbg_state (current FSM state, 0 = ACCUM, 1 = DONE)
//
// Handshake semantics (both streams): a transfer happens on the rising clock
// edge where valid && ready are both 1. The producer must hold valid and data
// stable until that edge; ready may be asserted or withdrawn freely and never
// depends combinationally on valid.
//
// Modports:
//   master : the environment (drives samples in, consumes results)
//   slave  : the accumulator
// ---------------------------------------------------------------------------
interface bm_dag3_accum_if #(
  parameter int BITS     = 2,
  parameter int ACC_BITS = 8
);
  logic                in_valid;
  logic [BITS-1:0]     in_data;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_BITS-1:0] out_sum;
  logic [BITS-1:0]     out_max;
  logic [BITS-1:0]     out_min;
  logic                out_ovf;
  logic                dbg_state;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_min, out_ovf, dbg_state
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_min, out_ovf, dbg_state
  );
endinterface

// File: rtl/bm_dag3_accum.sv
// ---------------------------------------------------------------------------
// bm_dag3_accum
//
// Windowed result accumulator. It consumes one BITS-wide unsigned sample per
// accepted cycle, and after WINDOW samples it presents the window sum (modulo
// 2^ACC_BITS), the max, the min and a sticky overflow flag. One result is
// held at a time; while it is held, upstream sees in_ready = 0.
//
// Parameters:
//   BITS     : sample width
//   WINDOW   : samples per window (1..65535)
//   ACC_BITS : sum width (>= BITS)
//
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : bm_dag3_accum_if.slave (input stream, output stream, dbg_state)
//
// Both in_ready and out_valid are decoded straight from the state register,
// so there is no combinational path from in_valid/out_ready to any output.
// ---------------------------------------------------------------------------
module bm_dag3_accum #(
  parameter int BITS     = 2,
  parameter int WINDOW   = 4,
  parameter int ACC_BITS = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  bm_dag3_accum_if.slave bus
);

  localparam int               CNT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t              state;
  logic [ACC_BITS-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_acc;
  logic [BITS-1:0]     cur_max;
  logic [BITS-1:0]     cur_min;

  logic [ACC_BITS-1:0] out_sum_q;
  logic [BITS-1:0]     out_max_q;
  logic [BITS-1:0]     out_min_q;
  logic                out_ovf_q;

  // Next-value datapath for the sample being offered this cycle.
  logic                accept;
  logic                last;
  logic [ACC_BITS:0]   sum_ext;
  logic                ovf_nxt;
  logic [BITS-1:0]     max_nxt;
  logic [BITS-1:0]     min_nxt;

  always_comb begin
    accept  = 1'b0;
    last    = 1'b0;
    sum_ext = '0;
    ovf_nxt = 1'b0;
    max_nxt = '0;
    min_nxt = '0;

    accept  = bus.in_valid && (state == ACCUM);
    last    = (cnt == CNT_LAST);

    // One extra bit catches the carry out of the ACC_BITS-wide sum.
    sum_ext = {1'b0, acc} + {{(ACC_BITS + 1 - BITS){1'b0}}, bus.in_data};
    ovf_nxt = ovf_acc | sum_ext[ACC_BITS];

    // The first sample of a window seeds max/min; older values are stale.
    if (cnt == '0) begin
      max_nxt = bus.in_data;
      min_nxt = bus.in_data;
    end else begin
      max_nxt = (bus.in_data > cur_max) ? bus.in_data : cur_max;
      min_nxt = (bus.in_data < cur_min) ? bus.in_data : cur_min;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      cur_max   <= '0;
      cur_min   <= '0;
      out_sum_q <= '0;
      out_max_q <= '0;
      out_min_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            cur_max <= max_nxt;
            cur_min <= min_nxt;
            if (last) begin
              // Window complete: publish including this sample, restart.
              out_sum_q <= sum_ext[ACC_BITS-1:0];
              out_max_q <= max_nxt;
              out_min_q <= min_nxt;
              out_ovf_q <= ovf_nxt;
              acc       <= '0;
              cnt       <= '0;
              ovf_acc   <= 1'b0;
              state     <= DONE;
            end else begin
              acc     <= sum_ext[ACC_BITS-1:0];
              cnt     <= cnt + CNT_W'(1);
              ovf_acc <= ovf_nxt;
            end
          end
        end
        DONE: begin
          // Result registers hold; the cycle after the handshake is the
          // earliest cycle in which a new sample can be accepted.
          if (bus.out_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_bm_dag3_accum.sv
// ---------------------------------------------------------------------------
// tb_bm_dag3_accum
//
// Three accumulator instances share clock and reset:
//   dut 0 (u_a) : WINDOW=4, ACC_BITS=8
//   dut 1 (u_b) : WINDOW=4, ACC_BITS=3
//   dut 2 (u_c) : WINDOW=1, ACC_BITS=8
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge.
// ---------------------------------------------------------------------------
module tb_bm_dag3_accum;

  localparam int F_RDY = 0;
  localparam int F_VLD = 1;
  localparam int F_SUM = 2;
  localparam int F_MAX = 3;
  localparam int F_MIN = 4;
  localparam int F_OVF = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  bm_dag3_accum_if #(.BITS(2), .ACC_BITS(8)) bus_a ();
  bm_dag3_accum_if #(.BITS(2), .ACC_BITS(3)) bus_b ();
  bm_dag3_accum_if #(.BITS(2), .ACC_BITS(8)) bus_c ();

  bm_dag3_accum #(.BITS(2), .WINDOW(4), .ACC_BITS(8)) u_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a)
  );
  bm_dag3_accum #(.BITS(2), .WINDOW(4), .ACC_BITS(3)) u_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b)
  );
  bm_dag3_accum #(.BITS(2), .WINDOW(1), .ACC_BITS(8)) u_c (
    .clock(clock), .reset_n(reset_n), .bus(bus_c)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];   // expected window sums, in completion order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int dut, input int field);
    logic [31:0] v;
    v = '0;
    case (dut)
      0: case (field)
           F_RDY: v = 32'(bus_a.in_ready);
           F_VLD: v = 32'(bus_a.out_valid);
           F_SUM: v = 32'(bus_a.out_sum);
           F_MAX: v = 32'(bus_a.out_max);
           F_MIN: v = 32'(bus_a.out_min);
           default: v = 32'(bus_a.out_ovf);
         endcase
      1: case (field)
           F_RDY: v = 32'(bus_b.in_ready);
           F_VLD: v = 32'(bus_b.out_valid);
           F_SUM: v = 32'(bus_b.out_sum);
           F_MAX: v = 32'(bus_b.out_max);
           F_MIN: v = 32'(bus_b.out_min);
           default: v = 32'(bus_b.out_ovf);
         endcase
      default: case (field)
           F_RDY: v = 32'(bus_c.in_ready);
           F_VLD: v = 32'(bus_c.out_valid);
           F_SUM: v = 32'(bus_c.out_sum);
           F_MAX: v = 32'(bus_c.out_max);
           F_MIN: v = 32'(bus_c.out_min);
           default: v = 32'(bus_c.out_ovf);
         endcase
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int dut, input logic v, input logic [1:0] d);
    case (dut)
      0: begin bus_a.in_valid = v; bus_a.in_data = d; end
      1: begin bus_b.in_valid = v; bus_b.in_data = d; end
      default: begin bus_c.in_valid = v; bus_c.in_data = d; end
    endcase
  endtask

  // Called on a falling edge; offers one sample across the next rising edge.
  task automatic drive_sample(input int dut, input logic [1:0] d);
    check("feed_in_ready", rd(dut, F_RDY), 1);
    set_in(dut, 1'b1, d);
    @(negedge clock);
    set_in(dut, 1'b0, 2'd0);
  endtask

  // Called on the falling edge right after the last accept of a window.
  task automatic check_result(input int dut, input string tag,
                              input logic [1:0] emax, input logic [1:0] emin,
                              input logic eovf);
    logic [7:0] esum;
    check({tag, "_valid"}, rd(dut, F_VLD), 1);
    check({tag, "_in_ready"}, rd(dut, F_RDY), 0);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 1, 0);
    end else begin
      esum = exp_q.pop_front();
      check({tag, "_sum"}, rd(dut, F_SUM), 32'(esum));
    end
    check({tag, "_max"}, rd(dut, F_MAX), 32'(emax));
    check({tag, "_min"}, rd(dut, F_MIN), 32'(emin));
    check({tag, "_ovf"}, rd(dut, F_OVF), 32'(eovf));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0;
    set_in(0, 1'b0, 2'd0);
    set_in(1, 1'b0, 2'd0);
    set_in(2, 1'b0, 2'd0);
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    bus_c.out_ready = 1'b1;

    repeat (2) @(negedge clock);
    check("rst_in_ready", rd(0, F_RDY), 1);
    check("rst_valid", rd(0, F_VLD), 0);
    check("rst_sum", rd(0, F_SUM), 0);
    check("rst_max", rd(0, F_MAX), 0);
    check("rst_min", rd(0, F_MIN), 0);
    check("rst_ovf", rd(0, F_OVF), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic window 1,3,2,0 -> sum 6, max 3, min 0.
    exp_q.push_back(8'd6);
    drive_sample(0, 2'd1);
    drive_sample(0, 2'd3);
    drive_sample(0, 2'd2);
    drive_sample(0, 2'd0);
    check_result(0, "basic", 2'd3, 2'd0, 1'b0);
    @(negedge clock);
    check("basic_bubble_in_ready", rd(0, F_RDY), 1);
    check("basic_bubble_valid", rd(0, F_VLD), 0);
    check("basic_hold_sum", rd(0, F_SUM), 6);

    // Input gaps 3,_,_,1,_,2,0 -> sum 6, max 3, min 0.
    exp_q.push_back(8'd6);
    drive_sample(0, 2'd3);
    repeat (2) @(negedge clock);
    drive_sample(0, 2'd1);
    @(negedge clock);
    drive_sample(0, 2'd2);
    check("gaps_valid_before_last", rd(0, F_VLD), 0);
    drive_sample(0, 2'd0);
    check_result(0, "gaps", 2'd3, 2'd0, 1'b0);
    @(negedge clock);

    // Backpressure: hold the 2,2,2,2 result while upstream pushes 3s.
    bus_a.out_ready = 1'b0;
    exp_q.push_back(8'd8);
    for (int i = 0; i < 4; i++) drive_sample(0, 2'd2);
    check_result(0, "bp", 2'd2, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b1, 2'd3);
      @(negedge clock);
      check("bp_in_ready", rd(0, F_RDY), 0);
      check("bp_valid", rd(0, F_VLD), 1);
      check("bp_sum", rd(0, F_SUM), 8);
      check("bp_max", rd(0, F_MAX), 2);
      check("bp_min", rd(0, F_MIN), 2);
    end
    set_in(0, 1'b0, 2'd0);
    bus_a.out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_in_ready", rd(0, F_RDY), 1);
    check("bp_release_valid", rd(0, F_VLD), 0);
    // Any 3 swallowed during DONE would corrupt this window.
    exp_q.push_back(8'd4);
    for (int i = 0; i < 4; i++) drive_sample(0, 2'd1);
    check_result(0, "post_bp", 2'd1, 2'd1, 1'b0);
    @(negedge clock);

    // Reset mid-window: 3,3 are discarded.
    drive_sample(0, 2'd3);
    drive_sample(0, 2'd3);
    reset_n = 1'b0;
    #1;
    check("rst_mid_in_ready", rd(0, F_RDY), 1);
    check("rst_mid_valid", rd(0, F_VLD), 0);
    check("rst_mid_sum", rd(0, F_SUM), 0);
    check("rst_mid_max", rd(0, F_MAX), 0);
    check("rst_mid_min", rd(0, F_MIN), 0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back(8'd4);
    for (int i = 0; i < 4; i++) drive_sample(0, 2'd1);
    check_result(0, "rst_mid", 2'd1, 2'd1, 1'b0);
    @(negedge clock);

    // Reset while holding a result: out_valid drops without a clock edge.
    bus_a.out_ready = 1'b0;
    exp_q.push_back(8'd6);
    drive_sample(0, 2'd2);
    drive_sample(0, 2'd1);
    drive_sample(0, 2'd2);
    drive_sample(0, 2'd1);
    check_result(0, "pre_rst_done", 2'd2, 2'd1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_done_valid", rd(0, F_VLD), 0);
    check("rst_done_in_ready", rd(0, F_RDY), 1);
    check("rst_done_sum", rd(0, F_SUM), 0);
    @(negedge clock);
    reset_n = 1'b1;
    bus_a.out_ready = 1'b1;
    @(negedge clock);

    // Overflow with ACC_BITS=3: 3+3+3+0 = 9 -> 1 with ovf.
    exp_q.push_back(8'd1);
    drive_sample(1, 2'd3);
    drive_sample(1, 2'd3);
    drive_sample(1, 2'd3);
    drive_sample(1, 2'd0);
    check_result(1, "ovf", 2'd3, 2'd0, 1'b1);
    @(negedge clock);
    exp_q.push_back(8'd4);
    for (int i = 0; i < 4; i++) drive_sample(1, 2'd1);
    check_result(1, "ovf_clear", 2'd1, 2'd1, 1'b0);
    @(negedge clock);

    // WINDOW=1: every sample is a window; one bubble between results.
    exp_q.push_back(8'd2);
    drive_sample(2, 2'd2);
    check_result(2, "w1_first", 2'd2, 2'd2, 1'b0);
    @(negedge clock);
    check("w1_gap_valid", rd(2, F_VLD), 0);
    exp_q.push_back(8'd1);
    drive_sample(2, 2'd1);
    check_result(2, "w1_second", 2'd1, 2'd1, 1'b0);
    @(negedge clock);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bm_dag3_accum.md
# bm_dag3_accum

Windowed result accumulator sitting directly downstream of the 2-bit DAG arithmetic micro-benchmark. It consumes the `BITS`-wide result stream one sample per accepted cycle and accumulates `WINDOW` samples. It then presents the window sum, max, min and overflow flag on a valid/ready output port. The block holds a single result and applies backpressure upstream until that result is taken.

## Interface
- `BITS`, 2: width of each incoming result sample.
- `WINDOW`, 4: samples per accumulation window; legal range 1..65535.
- `ACC_BITS`, 8: width of the accumulated sum; must be ≥ `BITS`.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_data` in `BITS`: unsigned result sample from the upstream DAG stage.
- `in_ready` out 1: block accepts a sample this cycle.
- `out_valid` out 1: window result is available.
- `out_ready` in 1: downstream consumer takes the result.
- `out_sum` out `ACC_BITS`: sum of the window samples, modulo 2^`ACC_BITS`.
- `out_max` out `BITS`: largest sample in the window.
- `out_min` out `BITS`: smallest sample in the window.
- `out_ovf` out 1: the sum exceeded 2^`ACC_BITS`−1 at some point during the window.

## Operation
- The FSM has two states: ACCUM (reset state) and DONE.
- Decoded outputs: `in_ready` = (state==ACCUM); `out_valid` = (state==DONE).
- A sample is accepted when `in_valid && in_ready`. Cycles without an accept leave all internal state unchanged; gaps are legal.
- On accept in ACCUM:
  - `acc` ← `acc` + zero-extended `in_data`, computed with one extra carry bit.
  - A carry out sets sticky `ovf_acc`.
  - `cnt` increments.
  - `cur_max`/`cur_min` update with unsigned compare.
  - When `cnt`==0, the sample loads both `cur_max` and `cur_min` directly (no compare).
- When the accepted sample is the `WINDOW`-th (`cnt`==`WINDOW`−1):
  - The final values are written, including this sample, into `out_sum`, `out_max`, `out_min` and `out_ovf`.
  - `acc`, `cnt` and `ovf_acc` clear.
  - State → DONE.
- `WINDOW`==1: every accepted sample completes a window. `out_sum` = `out_max` = `out_min` = the sample; `out_ovf` = 0.
- DONE:
  - `in_ready` = 0; upstream `in_valid` is ignored.
  - The output registers hold stable until the cycle where `out_ready` is 1, then state → ACCUM.
- Output registers change only on the window-complete transfer. They keep their last value while in ACCUM.
- `cnt` width = clog2(`WINDOW`), minimum 1 bit.

## Timing
- Reset (asynchronous assert, any cycle, including mid-window or in DONE):
  - State → ACCUM.
  - `acc`, `cnt`, `ovf_acc`, `cur_max`, `cur_min`, `out_sum`, `out_max`, `out_min`, `out_ovf` → 0.
  - Consequently `in_ready` = 1 and `out_valid` = 0 during reset and after it.
  - A partially collected window is discarded.
- Latency: `out_valid` rises in the cycle after the edge that accepted the `WINDOW`-th sample.
- `out_valid`, once high, stays high with stable data until the output handshake.
- After the output handshake edge, `in_ready` is 1 in the next cycle. There is one mandatory bubble: the earliest next accept is the cycle after the handshake.
- Best-case throughput is `WINDOW` samples per `WINDOW`+1 cycles.
- No combinational path from `in_valid` or `out_ready` to any output.

## Test plan
- **Basic window**, `WINDOW`=4, `ACC_BITS`=8, samples 1,3,2,0 on consecutive cycles, `out_ready`=1 → `out_valid` high 1 cycle after the 4th accept, with `out_sum`=6, `out_max`=3, `out_min`=0, `out_ovf`=0; `in_ready` low exactly 1 cycle.
- **Overflow**, `ACC_BITS`=3, samples 3,3,3,0 → `out_sum`=1 (9 mod 8), `out_ovf`=1. A following window of 1,1,1,1 → `out_sum`=4, `out_ovf`=0 (sticky cleared per window).
- **Backpressure**: complete a window of 2,2,2,2, then hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with `in_data`=3 → outputs stay `out_sum`=8, `out_max`=`out_min`=2; `in_ready`=0 and no sample accepted. Raise `out_ready` → `in_ready`=1 next cycle.
- **Input gaps**: samples 3,_,_,1,_,2,0 (where _ = `in_valid` low) → `out_sum`=6, `out_max`=3, `out_min`=0; `out_valid` rises the cycle after the sample 0 is accepted.
- **Reset mid-window**: accept 3,3, pulse `reset_n` low, then feed 1,1,1,1 → all outputs read 0 during reset; result `out_sum`=4, `out_max`=`out_min`=1. Also assert reset while in DONE → `out_valid` drops immediately (asynchronous).
- **`WINDOW`=1**: samples 2 then 1 with `out_ready`=1 → two results, `out_sum`=2 then 1, each with max=min=sample, separated by one bubble cycle.
